// File: rtl/mmio_controller_pkg.sv
// Shared I/O address map and STATUS register bit positions for the MMIO controller.
`default_nettype none

package mmio_controller_pkg;

   localparam logic [7:0] IO_LED_BASE = 8'h60;
   localparam logic [7:0] IO_SW       = 8'h70;
   localparam logic [7:0] IO_STATUS   = 8'h20;

   localparam int STATUS_BTN_BIT = 0;
   localparam int STATUS_ERR_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/mmio_controller_io_debounce.sv
// io_debounce: two-flop synchroniser followed by a single counter shared by the whole vector.
// Rev 1.0
`default_nettype none

module io_debounce #(
   parameter int WIDTH  = 1,
   parameter int CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable,
   output logic             update
);

   localparam int CNT_W = $clog2(CYCLES);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt;

   // High in the cycle before stable takes the synchronised value.
   assign update = (sync2 != stable) && (cnt == CNT_W'(CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         cnt    <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (update) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mmio_controller.sv
// mmio_controller: address decode, LED registers, debounced inputs, sticky flags and write-back mux.
// Rev 1.0
`default_nettype none

module mmio_controller
   import mmio_controller_pkg::*;
#(
   parameter int NUM_LED_CH   = 3,
   parameter int LED_W        = 8,
   parameter int SW_W         = 16,
   parameter int DEBOUNCE_CYC = 100000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mRead,
   input  logic                        mWrite,
   input  logic                        ioRead,
   input  logic                        ioWrite,
   input  logic [31:0]                 addr_in,
   input  logic [31:0]                 Mdata,
   input  logic [31:0]                 Rdata,
   input  logic [SW_W-1:0]             sw_in,
   input  logic                        btn_in,
   output logic [31:0]                 addr,
   output logic [31:0]                 r_data,
   output logic [31:0]                 w_data,
   output logic [NUM_LED_CH*LED_W-1:0] led_out
);

   logic [NUM_LED_CH*LED_W-1:0] led_q;
   logic [NUM_LED_CH-1:0]       led_hit;
   logic [LED_W-1:0]            led_rd;
   logic                        sw_hit;
   logic                        status_hit;
   logic                        err_set;
   logic                        status_clr;
   logic                        btn_rise;
   logic                        btn_flag;
   logic                        err_flag;
   logic [SW_W-1:0]             sw_stable;
   logic                        sw_update;
   logic                        btn_stable;
   logic                        btn_update;
   logic [31:0]                 status_word;
   logic                        unused_ok;

   assign addr    = addr_in;
   assign w_data  = (mWrite || ioWrite) ? Rdata : 32'h0;
   assign led_out = led_q;

   // mRead is part of the decoder interface but carries no meaning here.
   assign unused_ok = ^{mRead, sw_update};

   always_comb begin
      led_hit = '0;
      led_rd  = '0;
      for (int i = 0; i < NUM_LED_CH; i++) begin
         if (addr_in[7:0] == 8'(IO_LED_BASE + 4 * i)) begin
            led_hit[i] = 1'b1;
            led_rd     = led_q[i*LED_W +: LED_W];
         end
      end
   end

   assign sw_hit     = (addr_in[7:0] == IO_SW);
   assign status_hit = (addr_in[7:0] == IO_STATUS);
   assign err_set    = (ioRead || ioWrite) && !((|led_hit) || sw_hit || status_hit);
   assign status_clr = ioRead && status_hit;
   assign btn_rise   = btn_update && !btn_stable;

   generate
      for (genvar g = 0; g < NUM_LED_CH; g++) begin : g_led
         always_ff @(posedge clk) begin
            if (rst) begin
               led_q[g*LED_W +: LED_W] <= '0;
            end else if (ioWrite && led_hit[g]) begin
               led_q[g*LED_W +: LED_W] <= Rdata[LED_W-1:0];
            end
         end
      end
   endgenerate

   // Setting has priority over the read-clear so an event is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_flag <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         btn_flag <= btn_rise || (btn_flag && !status_clr);
         err_flag <= err_set  || (err_flag && !status_clr);
      end
   end

   always_comb begin
      status_word                 = '0;
      status_word[STATUS_BTN_BIT] = btn_flag;
      status_word[STATUS_ERR_BIT] = err_flag;
   end

   always_comb begin
      r_data = Mdata;
      if (ioRead) begin
         r_data = '0;
         if (|led_hit) begin
            r_data[LED_W-1:0] = led_rd;
         end else if (sw_hit) begin
            r_data[SW_W-1:0] = sw_stable;
         end else if (status_hit) begin
            r_data = status_word;
         end
      end
   end

   io_debounce #(
      .WIDTH  (SW_W),
      .CYCLES (DEBOUNCE_CYC)
   ) u_sw_debounce (
      .clk    (clk),
      .rst    (rst),
      .din    (sw_in),
      .stable (sw_stable),
      .update (sw_update)
   );

   io_debounce #(
      .WIDTH  (1),
      .CYCLES (DEBOUNCE_CYC)
   ) u_btn_debounce (
      .clk    (clk),
      .rst    (rst),
      .din    (btn_in),
      .stable (btn_stable),
      .update (btn_update)
   );

endmodule

`default_nettype wire

// File: tb/tb_mmio_controller.sv
// Directed self-checking bench for mmio_controller with a short debounce window.
`default_nettype none

module tb_mmio_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        mRead;
   logic        mWrite;
   logic        ioRead;
   logic        ioWrite;
   logic [31:0] addr_in;
   logic [31:0] Mdata;
   logic [31:0] Rdata;
   logic [15:0] sw_in;
   logic        btn_in;
   logic [31:0] addr;
   logic [31:0] r_data;
   logic [31:0] w_data;
   logic [23:0] led_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mmio_controller #(
      .NUM_LED_CH   (3),
      .LED_W        (8),
      .SW_W         (16),
      .DEBOUNCE_CYC (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mRead   (mRead),
      .mWrite  (mWrite),
      .ioRead  (ioRead),
      .ioWrite (ioWrite),
      .addr_in (addr_in),
      .Mdata   (Mdata),
      .Rdata   (Rdata),
      .sw_in   (sw_in),
      .btn_in  (btn_in),
      .addr    (addr),
      .r_data  (r_data),
      .w_data  (w_data),
      .led_out (led_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      mRead   = 1'b0;
      mWrite  = 1'b0;
      ioRead  = 1'b0;
      ioWrite = 1'b0;
      addr_in = 32'h0;
      Mdata   = 32'h1111_2222;
      Rdata   = 32'h0;
      sw_in   = 16'h0;
      btn_in  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("reset_led", {8'h0, led_out}, 32'h0);
      check("reset_rdata_mem", r_data, 32'h1111_2222);
      ioRead  = 1'b1;
      addr_in = 32'h0000_0020;
      #1;
      check("reset_status", r_data, 32'h0);
      ioRead  = 1'b0;

      // LED channel 1 write
      ioWrite = 1'b1;
      addr_in = 32'hFFFF_FC64;
      Rdata   = 32'h1234_56A5;
      #1;
      check("io_wdata", w_data, 32'h1234_56A5);
      check("addr_pass", addr, 32'hFFFF_FC64);
      check("led_before_edge", {8'h0, led_out}, 32'h0);
      tick();
      ioWrite = 1'b0;
      #1;
      check("led_ch1_written", {8'h0, led_out}, 32'h0000_A500);
      ioRead = 1'b1;
      #1;
      check("led_ch1_read", r_data, 32'h0000_00A5);
      addr_in = 32'h0000_0060;
      #1;
      check("led_ch0_read", r_data, 32'h0);
      ioRead = 1'b0;
      Mdata  = 32'hDEAD_BEEF;
      #1;
      check("rdata_mem", r_data, 32'hDEAD_BEEF);

      // Switch debounce latency
      ioRead  = 1'b1;
      addr_in = 32'h0000_0070;
      sw_in   = 16'hBEEF;
      #1;
      check("sw_cycle0", r_data, 32'h0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("sw_cycle%0d", k), r_data, (k == 6) ? 32'h0000_BEEF : 32'h0);
      end
      // Two-cycle glitch must be rejected
      sw_in = 16'h0000;
      tick();
      tick();
      sw_in = 16'hBEEF;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("sw_glitch%0d", k), r_data, 32'h0000_BEEF);
      end
      ioRead = 1'b0;

      // Button pulse sets the sticky flag
      btn_in = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      btn_in = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      ioRead  = 1'b1;
      addr_in = 32'h0000_0020;
      #1;
      check("btn_status_set", r_data, 32'h1);
      tick();
      check("btn_status_cleared", r_data, 32'h0);
      ioRead = 1'b0;

      // Read-clear in the same cycle the debounced edge arrives
      btn_in = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      ioRead = 1'b1;
      #1;
      check("btn_race_before", r_data, 32'h0);
      tick();
      check("btn_race_set_wins", r_data, 32'h1);
      tick();
      check("btn_race_cleared", r_data, 32'h0);
      ioRead = 1'b0;
      btn_in = 1'b0;
      for (int k = 0; k < 8; k++) tick();

      // Unmapped LED channel
      ioWrite = 1'b1;
      addr_in = 32'h0000_006C;
      Rdata   = 32'hFFFF_FFFF;
      tick();
      ioWrite = 1'b0;
      #1;
      check("unmapped_led_unchanged", {8'h0, led_out}, 32'h0000_A500);
      ioRead  = 1'b1;
      addr_in = 32'h0000_0020;
      #1;
      check("err_flag_set", r_data, 32'h2);
      ioRead  = 1'b0;

      // Reset in the middle of a switch debounce
      sw_in = 16'h1234;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_led", {8'h0, led_out}, 32'h0);
      ioRead  = 1'b1;
      addr_in = 32'h0000_0020;
      #1;
      check("rst_status", r_data, 32'h0);
      addr_in = 32'h0000_0070;
      #1;
      check("rst_sw", r_data, 32'h0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("rst_sw_cycle%0d", k), r_data, (k == 6) ? 32'h0000_1234 : 32'h0);
      end
      ioRead = 1'b0;

      // Memory store path
      mWrite = 1'b1;
      Rdata  = 32'hCAFE_0001;
      #1;
      check("mem_wdata", w_data, 32'hCAFE_0001);
      check("mwrite_no_led", {8'h0, led_out}, 32'h0);
      mWrite = 1'b0;
      #1;
      check("idle_wdata", w_data, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
